// File: rtl/nbr_pkg.sv
// Shared types and bank mapping for the neighbour-to-bank arbiter.
// Lane bundle and the row/column to bank hash.
package nbr_pkg;

  localparam int DEF_TILE_SIZE  = 128;
  localparam int DEF_BANK_COUNT = 32;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int ADDR_W = $clog2(DEF_TILE_SIZE);
  localparam int BANK_W = $clog2(DEF_BANK_COUNT);

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] value;
    logic [ADDR_W-1:0]         row;
    logic [ADDR_W-1:0]         column;
  } lane_t;

  // banks is a power of two, so the final mask is the modulo
  function automatic logic [31:0] bank_from_rc(
    input logic [31:0] row,
    input logic [31:0] column,
    input logic [1:0]  bw,
    input logic [31:0] banks
  );
    logic [31:0] upper;
    logic [31:0] sect;
    upper = row >> bw;
    sect  = row & ((32'd1 << bw) - 32'd1);
    return (column + 32'd3 * upper + sect * (banks >> bw))
           & (banks - 32'd1);
  endfunction

endpackage

// File: rtl/neighbor_bank_arbiter_if.sv
// Batch handshake from the neighbour links and the
// per-bank write bus towards the accumulator buffer.
interface neighbor_bank_arbiter_if
  import nbr_pkg::*;
#(
  parameter int N     = 8,
  parameter int BANKS = DEF_BANK_COUNT,
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int AW    = ADDR_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic [N-1:0][DW-1:0]     neighbor_input_value;
  logic [N-1:0][AW-1:0]     neighbor_input_row;
  logic [N-1:0][AW-1:0]     neighbor_input_column;
  logic [N-1:0]             neighbor_input_we;
  logic [BANKS-1:0][AW-1:0] buffer_row_write;
  logic [BANKS-1:0][AW-1:0] buffer_column_write;
  logic [BANKS-1:0][DW-1:0] buffer_data_write;
  logic [BANKS-1:0]         buffer_write_enable;

  modport master (
    output in_valid, neighbor_input_value,
    output neighbor_input_row, neighbor_input_column,
    output neighbor_input_we,
    input  in_ready, buffer_row_write,
    input  buffer_column_write, buffer_data_write,
    input  buffer_write_enable
  );

  modport slave (
    input  in_valid, neighbor_input_value,
    input  neighbor_input_row, neighbor_input_column,
    input  neighbor_input_we,
    output in_ready, buffer_row_write,
    output buffer_column_write, buffer_data_write,
    output buffer_write_enable
  );

endinterface

// File: rtl/nbr_rr_bank_select.sv
// Round-robin lane scan: first claimant of a bank wins,
// later claimants of the same bank are reported as losers.
module nbr_rr_bank_select
  import nbr_pkg::*;
#(
  parameter int N     = 8,
  parameter int BANKS = DEF_BANK_COUNT,
  parameter int AW    = ADDR_W,
  parameter int NW    = $clog2(N),
  parameter int BW    = $clog2(BANKS)
) (
  input  logic [N-1:0]             cand,
  input  logic [N-1:0][AW-1:0]     row,
  input  logic [N-1:0][AW-1:0]     col,
  input  logic [NW-1:0]            rr_ptr,
  input  logic [1:0]               bitwidth,
  output logic [BANKS-1:0]         win_vld,
  output logic [BANKS-1:0][NW-1:0] win_lane,
  output logic [N-1:0]             lose
);

  logic [N-1:0][BW-1:0] bank;
  logic [NW-1:0]        ln;
  logic [BW-1:0]        bk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bank[i] = BW'(bank_from_rc(32'(row[i]),
                                 32'(col[i]),
                                 bitwidth,
                                 32'(BANKS)));
    end
  end

  always_comb begin
    win_vld  = '0;
    win_lane = '0;
    lose     = '0;
    ln       = '0;
    bk       = '0;
    for (int k = 0; k < N; k++) begin
      ln = NW'((32'(rr_ptr) + 32'(k)) % 32'(N));
      if (cand[ln]) begin
        bk = bank[ln];
        if (win_vld[bk]) begin
          lose[ln] = 1'b1;
        end else begin
          win_vld[bk]  = 1'b1;
          win_lane[bk] = ln;
        end
      end
    end
  end

endmodule

// File: rtl/neighbor_bank_arbiter.sv
// Routes neighbour-tile partial outputs into accumulator banks,
// one write per bank per cycle, draining conflicts round-robin.
module neighbor_bank_arbiter
  import nbr_pkg::*;
#(
  parameter int BANK_COUNT     = DEF_BANK_COUNT,
  parameter int TILE_SIZE      = DEF_TILE_SIZE,
  parameter int NEIGHBOR_COUNT = 8,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             bitwidth,
  neighbor_bank_arbiter_if.slave bus,
  output logic                   leftover_inputs,
  output logic [STALL_CNT_W-1:0] stall_count,
  input  logic                   stall_clear
);

  localparam int N  = NEIGHBOR_COUNT;
  localparam int AW = $clog2(TILE_SIZE);
  localparam int NW = $clog2(N);

  logic [N-1:0][DATA_WIDTH-1:0] hold_val;
  logic [N-1:0][AW-1:0]         hold_row;
  logic [N-1:0][AW-1:0]         hold_col;
  logic [N-1:0][DATA_WIDTH-1:0] cur_val;
  logic [N-1:0][AW-1:0]         cur_row;
  logic [N-1:0][AW-1:0]         cur_col;
  logic [N-1:0]                 pending;
  logic [N-1:0]                 cand;
  logic [N-1:0]                 lose;
  logic [NW-1:0]                rr_ptr;
  logic                         accept;
  logic [BANK_COUNT-1:0]          win_vld;
  logic [BANK_COUNT-1:0][NW-1:0]  win_lane;

  assign leftover_inputs = |pending;
  assign bus.in_ready    = ~leftover_inputs;
  assign accept  = bus.in_valid & bus.in_ready;
  assign cand    = accept ? bus.neighbor_input_we : pending;
  assign cur_val = accept ? bus.neighbor_input_value : hold_val;
  assign cur_row = accept ? bus.neighbor_input_row : hold_row;
  assign cur_col = accept ? bus.neighbor_input_column : hold_col;

  nbr_rr_bank_select #(
    .N     (N),
    .BANKS (BANK_COUNT),
    .AW    (AW)
  ) u_sel (
    .cand     (cand),
    .row      (cur_row),
    .col      (cur_col),
    .rr_ptr   (rr_ptr),
    .bitwidth (bitwidth),
    .win_vld  (win_vld),
    .win_lane (win_lane),
    .lose     (lose)
  );

  // losers of this cycle are exactly what is still owed
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_val <= '0;
      hold_row <= '0;
      hold_col <= '0;
      pending  <= '0;
      rr_ptr   <= '0;
    end else begin
      if (accept) begin
        hold_val <= bus.neighbor_input_value;
        hold_row <= bus.neighbor_input_row;
        hold_col <= bus.neighbor_input_column;
      end
      pending <= lose;
      if (|lose) begin
        rr_ptr <= NW'((32'(rr_ptr) + 32'd1) % 32'(N));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.buffer_write_enable <= '0;
      bus.buffer_data_write   <= '0;
      bus.buffer_row_write    <= '0;
      bus.buffer_column_write <= '0;
    end else begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        bus.buffer_write_enable[b] <= win_vld[b];
        bus.buffer_data_write[b]   <=
          win_vld[b] ? cur_val[win_lane[b]] : '0;
        bus.buffer_row_write[b]    <=
          win_vld[b] ? cur_row[win_lane[b]] : '0;
        bus.buffer_column_write[b] <=
          win_vld[b] ? cur_col[win_lane[b]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_clear) begin
      stall_count <= '0;
    end else if (leftover_inputs && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_neighbor_bank_arbiter.sv
// Directed scoreboard bench for neighbor_bank_arbiter: expected
// per-cycle bank writes are queued at drive time, popped each cycle.
module tb_neighbor_bank_arbiter;
  import nbr_pkg::*;

  localparam int N = 8;
  localparam int B = 32;

  typedef struct packed {
    logic [B-1:0] we;
    lane_t [B-1:0] ln;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [1:0]           bw;
  logic                 stall_clear;
  logic                 in_valid;
  logic [N-1:0][7:0]    val;
  logic [N-1:0][ADDR_W-1:0] row;
  logic [N-1:0][ADDR_W-1:0] col;
  logic [N-1:0]         we;
  logic                 left;
  logic                 left3;
  logic [15:0]          stall;
  logic [2:0]           stall3;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  neighbor_bank_arbiter_if #(.N(N), .BANKS(B), .DW(8), .AW(ADDR_W)) bus ();
  neighbor_bank_arbiter_if #(.N(N), .BANKS(B), .DW(8), .AW(ADDR_W)) bus3 ();

  assign bus.in_valid              = in_valid;
  assign bus.neighbor_input_value  = val;
  assign bus.neighbor_input_row    = row;
  assign bus.neighbor_input_column = col;
  assign bus.neighbor_input_we     = we;
  assign bus3.in_valid              = in_valid;
  assign bus3.neighbor_input_value  = val;
  assign bus3.neighbor_input_row    = row;
  assign bus3.neighbor_input_column = col;
  assign bus3.neighbor_input_we     = we;

  neighbor_bank_arbiter #(
    .BANK_COUNT(B), .TILE_SIZE(128), .NEIGHBOR_COUNT(N),
    .DATA_WIDTH(8), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bitwidth(bw), .bus(bus),
    .leftover_inputs(left), .stall_count(stall),
    .stall_clear(stall_clear)
  );

  neighbor_bank_arbiter #(
    .BANK_COUNT(B), .TILE_SIZE(128), .NEIGHBOR_COUNT(N),
    .DATA_WIDTH(8), .STALL_CNT_W(3)
  ) dut3 (
    .clk(clk), .reset(reset), .bitwidth(bw), .bus(bus3),
    .leftover_inputs(left3), .stall_count(stall3),
    .stall_clear(stall_clear)
  );

  task automatic chk_s(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_b(input string tag, input exp_t got,
                       input exp_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t obs();
    exp_t e;
    e.we = bus.buffer_write_enable;
    for (int b = 0; b < B; b++) begin
      e.ln[b] = {bus.buffer_data_write[b], bus.buffer_row_write[b],
                 bus.buffer_column_write[b]};
    end
    return e;
  endfunction

  function automatic exp_t wr(input int bk, input logic [7:0] d,
                              input logic [ADDR_W-1:0] r,
                              input logic [ADDR_W-1:0] c);
    exp_t e;
    e = '0;
    e.we[bk] = 1'b1;
    e.ln[bk] = {d, r, c};
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    chk_b("bufwr", obs(), e);
    chk_s("we3", bus3.buffer_write_enable, e.we);
  endtask

  task automatic clr_in();
    in_valid = 1'b0;
    we  = '0;
    val = '0;
    row = '0;
    col = '0;
  endtask

  task automatic conflict_batch(input logic [7:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      val[i] = base + 8'(i);
      row[i] = '0;
      col[i] = 7'd5;
    end
    we = '1;
  endtask

  initial begin
    reset = 1'b1;
    bw = 2'd0;
    stall_clear = 1'b0;
    clr_in();
    tick();
    tick();
    chk_s("rst_ready", 32'(bus.in_ready), 1);
    chk_s("rst_stall", 32'(stall), 0);
    chk_s("rst_left", 32'(left), 0);
    reset = 1'b0;

    // spread: row0 col0..7 -> banks 0..7
    in_valid = 1'b1;
    we = '1;
    for (int i = 0; i < N; i++) begin
      val[i] = 8'h10 + 8'(i);
      row[i] = '0;
      col[i] = 7'(i);
    end
    begin
      exp_t e;
      e = '0;
      for (int i = 0; i < N; i++) e = e | wr(i, 8'h10 + 8'(i), 7'd0, 7'(i));
      q.push_back(e);
    end
    tick();
    chk_s("t1_ready", 32'(bus.in_ready), 1);
    clr_in();
    tick();

    // bitwidth 2: row5 col0 -> bank 11
    bw = 2'd2;
    in_valid = 1'b1;
    we[2] = 1'b1; val[2] = 8'h5A; row[2] = 7'd5; col[2] = 7'd0;
    q.push_back(wr(11, 8'h5A, 7'd5, 7'd0));
    tick();
    // bitwidth 1: row3 col2 -> bank 21
    clr_in();
    bw = 2'd1;
    in_valid = 1'b1;
    we[6] = 1'b1; val[6] = 8'hC3; row[6] = 7'd3; col[6] = 7'd2;
    q.push_back(wr(21, 8'hC3, 7'd3, 7'd2));
    tick();
    // valid with no enables: accepted, nothing written
    clr_in();
    in_valid = 1'b1;
    tick();
    chk_s("nowe_ready", 32'(bus.in_ready), 1);
    clr_in();
    bw = 2'd0;
    tick();

    // reset in the middle of an 8-way drain
    conflict_batch(8'h20);
    q.push_back(wr(5, 8'h20, 7'd0, 7'd5));
    q.push_back(wr(5, 8'h21, 7'd0, 7'd5));
    tick();
    clr_in();
    tick();
    chk_s("mid_stall_pre", 32'(stall), 1);
    q.delete();
    reset = 1'b1;
    tick();
    chk_s("mid_ready", 32'(bus.in_ready), 1);
    chk_s("mid_stall", 32'(stall), 0);
    chk_s("mid_left", 32'(left), 0);
    reset = 1'b0;

    // batches A then B, lanes 0,1 both on bank 4
    in_valid = 1'b1;
    we = 8'b0000_0011;
    val[0] = 8'hA0; val[1] = 8'hA1;
    col[0] = 7'd4;  col[1] = 7'd4;
    q.push_back(wr(4, 8'hA0, 7'd0, 7'd4));
    q.push_back(wr(4, 8'hA1, 7'd0, 7'd4));
    q.push_back(wr(4, 8'hB1, 7'd0, 7'd4));
    q.push_back(wr(4, 8'hB0, 7'd0, 7'd4));
    tick();
    chk_s("ab_ready0", 32'(bus.in_ready), 0);
    val[0] = 8'hB0; val[1] = 8'hB1;
    tick();
    chk_s("ab_ready1", 32'(bus.in_ready), 1);
    tick();
    clr_in();
    tick();
    tick();
    chk_s("ab_q_empty", 32'(q.size()), 0);

    // two 8-way batches back to back, stall saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    conflict_batch(8'h01);
    for (int i = 0; i < N; i++)
      q.push_back(wr(5, 8'h01 + 8'(i), 7'd0, 7'd5));
    q.push_back(wr(5, 8'h18, 7'd0, 7'd5));
    for (int i = 0; i < N - 1; i++)
      q.push_back(wr(5, 8'h11 + 8'(i), 7'd0, 7'd5));
    tick();
    chk_s("c_ready_1", 32'(bus.in_ready), 0);
    conflict_batch(8'h11);
    for (int k = 2; k < N; k++) begin
      tick();
      chk_s("c_ready_drain", 32'(bus.in_ready), 0);
    end
    tick();
    chk_s("c_ready_8", 32'(bus.in_ready), 1);
    chk_s("c_stall_7", 32'(stall), 7);
    chk_s("c_stall3_7", 32'(stall3), 7);
    tick();
    clr_in();
    chk_s("c_ready_9", 32'(bus.in_ready), 0);
    tick();
    tick();
    tick();
    chk_s("c_stall_10", 32'(stall), 10);
    chk_s("c_stall3_sat", 32'(stall3), 7);
    stall_clear = 1'b1;
    tick();
    stall_clear = 1'b0;
    chk_s("c_clr", 32'(stall), 0);
    chk_s("c_clr3", 32'(stall3), 0);
    tick();
    tick();
    tick();
    chk_s("c_stall_3", 32'(stall), 3);
    chk_s("c_stall3_3", 32'(stall3), 3);
    chk_s("c_ready_end", 32'(bus.in_ready), 1);
    tick();
    chk_s("c_stall_hold", 32'(stall), 3);
    chk_s("c_q_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
